// File: rtl/and_result_buffer.sv
// Result buffer behind the 8-bit AND unit: small show-ahead FIFO with per-entry zero/parity flags.
// Optional feature macro: RESULT_PARITY_EN (stores a parity bit per entry and drives out_parity).
module and_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_parity,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef RESULT_PARITY_EN
  localparam int ENTRY_W = WIDTH + 2;
`else
  localparam int ENTRY_W = WIDTH + 1;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  assign in_ready  = !rst && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags are captured alongside the data so the consumer never recomputes them.
`ifdef RESULT_PARITY_EN
  assign wr_entry = {in_data, ~|in_data, ^in_data};
`else
  assign wr_entry = {in_data, ~|in_data};
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Show-ahead head, masked to zero while empty so stale entries never leak out.
  assign head = out_valid ? mem[rd_ptr] : '0;

`ifdef RESULT_PARITY_EN
  assign out_data   = head[ENTRY_W-1:2];
  assign out_zero   = head[1];
  assign out_parity = head[0];
`else
  assign out_data   = head[ENTRY_W-1:1];
  assign out_zero   = head[0];
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_and_result_buffer.sv
// Scoreboard bench for and_result_buffer: expected entries queued on accepted pushes,
// compared against the show-ahead head every cycle.
module tb_and_result_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
`ifdef RESULT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_zero;
  logic                   out_parity;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;
  logic [WIDTH-1:0] sb_q[$];

  and_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] d);
    return PAR_EN ? ^d : 1'b0;
  endfunction

  // Called just after a negedge: drive inputs, check current state, update model, advance.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_count != DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_count != 0));
    check("count", 32'(count), 32'(exp_count));
    if (sb_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(sb_q[0]));
      check("out_zero", 32'(out_zero), 32'(sb_q[0] == '0));
      check("out_parity", 32'(out_parity), 32'(exp_par(sb_q[0])));
    end else begin
      check("empty_data", 32'(out_data), 32'h0);
      check("empty_zero", 32'(out_zero), 32'h0);
      check("empty_parity", 32'(out_parity), 32'h0);
    end
    do_push = iv && (exp_count != DEPTH);
    do_pop  = ordy && (exp_count != 0);
    if (do_pop) void'(sb_q.pop_front());
    if (do_push) sb_q.push_back(d);
    exp_count = exp_count + int'(do_push) - int'(do_pop);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single push B8&09 = 08, then observe it
    step(1'b1, 8'hB8 & 8'h09, 1'b0);
    #1;
    check("t2_out_data", 32'(out_data), 32'h08);
    check("t2_out_parity", 32'(out_parity), 32'(PAR_EN));
    step(1'b0, 8'h00, 1'b0);

    // second push 00, then a push of A8 while full must be dropped
    step(1'b1, 8'hB8 & 8'h47, 1'b0);
    step(1'b1, 8'hA8, 1'b0);
    step(1'b1, 8'hA8, 1'b1);
    check("t3_count_after_full", 32'(count), 32'h1);

    // drain remaining; then empty
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    #1;
    check("t4_empty_data", 32'(out_data), 32'h0);
    check("t4_empty_count", 32'(count), 32'h0);

    // count=1 with simultaneous push+pop, across several wraps
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h28, 1'b1);
    #1;
    check("t5_head_28", 32'(out_data), 32'h28);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h30 + 8'(i * 7)), 1'b1);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom & $urandom), 1'($urandom_range(0, 1)));
    end
    while (exp_count != 0) step(1'b0, 8'h00, 1'b1);

    // mid-stream async reset with two entries held
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h81, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t1_rst_count", 32'(count), 32'h0);
    check("t1_rst_out_valid", 32'(out_valid), 32'h0);
    check("t1_rst_in_ready", 32'(in_ready), 32'h0);
    check("t1_rst_out_data", 32'(out_data), 32'h0);
    sb_q.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_release_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
